cpu_pipe: RTL and testbench

Parametrised successor to the single-cycle datapath. It is a two-stage (issue / execute-writeback) register-register CPU core with a valid/ready instruction port. It forwards the in-flight result to the next instruction. Shifts can be iterative (multi-cycle, stalling issue) or single-cycle barrel. The core sits between an instruction source (test sequencer or future fetch unit) and a writeback observation port used by benches and later by a trace unit.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/cpu_pipe_if.sv | 16 +
 rtl/cpu_shift_unit.sv | 66 ++++++
 rtl/cpu_pipe.sv | 127 ++++++++++++
 tb/tb_cpu_pipe.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the two-stage cpu_pipe core: opcodes, stage-1 states
// and instruction field positions.
package cpu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_AND  = 3'b001;
  localparam opcode_t OP_NAND = 3'b010;
  localparam opcode_t OP_OR   = 3'b011;
  localparam opcode_t OP_XOR  = 3'b100;
  localparam opcode_t OP_SGT  = 3'b101;
  localparam opcode_t OP_SLL  = 3'b110;
  localparam opcode_t OP_SRL  = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // Field positions in units of RA_WIDTH, counted from the LSB.
  localparam int FLD_RS2  = 0;
  localparam int FLD_RS1  = 1;
  localparam int FLD_DEST = 2;
  localparam int FLD_OP   = 3;

  function automatic logic is_shift(opcode_t op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/cpu_pipe_if.sv
// Instruction issue and writeback observation bundle for cpu_pipe.
interface cpu_pipe_if #(
  parameter int D_WIDTH   = 32,
  parameter int RA_WIDTH  = 5,
  parameter int INS_WIDTH = 18
);
  logic [INS_WIDTH-1:0] ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic                 wb_valid;
  logic [RA_WIDTH-1:0]  wb_addr;
  logic [D_WIDTH-1:0]   wb_data;

  modport master (output ins, ins_valid, input ins_ready, wb_valid, wb_addr, wb_data);
  modport slave  (input ins, ins_valid, output ins_ready, wb_valid, wb_addr, wb_data);
endinterface

// File: rtl/cpu_shift_unit.sv
// Shift operand holder: either shifts one bit per cycle while the count runs
// down, or computes the full barrel result when the shift is accepted.
module cpu_shift_unit
  import cpu_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int RA_WIDTH   = 5,
  parameter int SHIFT_ITER = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                left_i,
  input  logic [D_WIDTH-1:0]  opnd_i,
  input  logic [RA_WIDTH-1:0] shamt_i,
  output logic                done_o,
  output logic [D_WIDTH-1:0]  result_o
);
  logic [D_WIDTH-1:0]  opnd_q, opnd_d;
  logic [RA_WIDTH-1:0] cnt_q, cnt_d;

  generate
    if (SHIFT_ITER != 0) begin : g_iter
      logic left_q;

      always_comb begin
        cnt_d  = cnt_q;
        opnd_d = opnd_q;
        if (start_i) begin
          cnt_d  = shamt_i;
          opnd_d = opnd_i;
        end else if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          opnd_d = left_q ? (opnd_q << 1) : (opnd_q >> 1);
        end
      end

      always_ff @(posedge clk) begin
        if (start_i) left_q <= left_i;
      end
    end else begin : g_barrel
      always_comb begin
        cnt_d  = '0;
        opnd_d = opnd_q;
        if (start_i) begin
          if (32'(shamt_i) >= D_WIDTH) opnd_d = '0;
          else opnd_d = left_i ? (opnd_i << shamt_i) : (opnd_i >> shamt_i);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    opnd_q <= opnd_d;
  end

  // The last single-bit step lands on the edge where the count leaves 1.
  assign done_o   = (SHIFT_ITER == 0) || (cnt_q == RA_WIDTH'(1));
  assign result_o = opnd_q;

endmodule

// File: rtl/cpu_pipe.sv
// Two-stage register-register core: issue reads operands (with distance-1
// forwarding), stage 1 executes and writes back on the following edge.
module cpu_pipe
  import cpu_pkg::*;
#(
  parameter int D_WIDTH    = 32,
  parameter int REG_CT     = 32,
  parameter int RA_WIDTH   = $clog2(REG_CT),
  parameter int OP_WIDTH   = 3,
  parameter int INS_WIDTH  = OP_WIDTH + 3 * RA_WIDTH,
  parameter int SHIFT_ITER = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_pipe_if.slave           bus,
  input  logic [RA_WIDTH-1:0] dbg_addr,
  output logic [D_WIDTH-1:0]  dbg_data
);
  logic [D_WIDTH-1:0] regs_q [REG_CT];

  state_t              state_q, state_d;
  opcode_t             op_q;
  logic [RA_WIDTH-1:0] dest_q;
  logic [D_WIDTH-1:0]  a_q, b_q;
  logic                wb_valid_q;
  logic [RA_WIDTH-1:0] wb_addr_q;
  logic [D_WIDTH-1:0]  wb_data_q;

  opcode_t             in_op;
  logic [RA_WIDTH-1:0] in_dest, in_rs1, in_rs2;
  logic [D_WIDTH-1:0]  opa, opb, result, sh_result;
  logic                ready_c, accept, retire, sh_done;

  function automatic logic [D_WIDTH-1:0] alu(opcode_t op, logic [D_WIDTH-1:0] a,
                                             logic [D_WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_NAND: return ~(a & b);
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SGT:  return (a > b) ? D_WIDTH'(1) : '0;
      default: return '0;
    endcase
  endfunction

  assign in_op   = opcode_t'(bus.ins[FLD_OP*RA_WIDTH +: OP_WIDTH]);
  assign in_dest = bus.ins[FLD_DEST*RA_WIDTH +: RA_WIDTH];
  assign in_rs1  = bus.ins[FLD_RS1*RA_WIDTH +: RA_WIDTH];
  assign in_rs2  = bus.ins[FLD_RS2*RA_WIDTH +: RA_WIDTH];

  assign retire = (state_q == ST_EXEC);
  assign accept = bus.ins_valid && ready_c;
  assign result = is_shift(op_q) ? sh_result : alu(op_q, a_q, b_q);

  // The instruction retiring this cycle overrides the stale register file.
  assign opa = (retire && dest_q == in_rs1) ? result : regs_q[in_rs1];
  assign opb = (retire && dest_q == in_rs2) ? result : regs_q[in_rs2];

  cpu_shift_unit #(
    .D_WIDTH   (D_WIDTH),
    .RA_WIDTH  (RA_WIDTH),
    .SHIFT_ITER(SHIFT_ITER)
  ) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept && is_shift(in_op)),
    .left_i  (in_op == OP_SLL),
    .opnd_i  (opa),
    .shamt_i (in_rs2),
    .done_o  (sh_done),
    .result_o(sh_result)
  );

  always_comb begin
    state_d = state_q;
    ready_c = 1'b1;
    case (state_q)
      ST_SHIFT: begin
        ready_c = 1'b0;
        if (sh_done) state_d = ST_EXEC;
      end
      default: begin
        if (bus.ins_valid) begin
          if (is_shift(in_op) && SHIFT_ITER != 0 && in_rs2 != '0) state_d = ST_SHIFT;
          else state_d = ST_EXEC;
        end else begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < REG_CT; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= retire;
      if (retire) begin
        regs_q[dest_q] <= result;
        wb_addr_q      <= dest_q;
        wb_data_q      <= result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= in_op;
      dest_q <= in_dest;
      a_q    <= opa;
      b_q    <= opb;
    end
  end

  assign bus.ins_ready = ready_c;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;
  assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_cpu_pipe.sv
// Scoreboard bench: an iterative-shift 32-bit core and a barrel-shift 16-bit core.
module tb_cpu_pipe;
  import cpu_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [4:0]  dbg_a, dbg_b;
  logic [31:0] dbgd_a;
  logic [15:0] dbgd_b;
  int checks = 0;
  int fails  = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  cpu_pipe_if #(.D_WIDTH(32), .RA_WIDTH(5), .INS_WIDTH(18)) a_if ();
  cpu_pipe_if #(.D_WIDTH(16), .RA_WIDTH(5), .INS_WIDTH(18)) b_if ();

  cpu_pipe #(.D_WIDTH(32), .REG_CT(32), .SHIFT_ITER(1)) dut_a (
    .clk(clk), .rst_n(rst_a), .bus(a_if), .dbg_addr(dbg_a), .dbg_data(dbgd_a)
  );
  cpu_pipe #(.D_WIDTH(16), .REG_CT(32), .SHIFT_ITER(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .bus(b_if), .dbg_addr(dbg_b), .dbg_data(dbgd_b)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] enc(opcode_t op, int d, int s1, int s2);
    return {op, 5'(d), 5'(s1), 5'(s2)};
  endfunction

  task automatic issue(bit sel, opcode_t op, int d, int s1, int s2, logic [31:0] exp,
                       bit push, output int waited);
    logic rdy;
    waited = 0;
    @(negedge clk);
    if (sel) begin b_if.ins = enc(op, d, s1, s2); b_if.ins_valid = 1'b1; end
    else     begin a_if.ins = enc(op, d, s1, s2); a_if.ins_valid = 1'b1; end
    rdy = sel ? b_if.ins_ready : a_if.ins_ready;
    while (!rdy && waited < 100) begin
      @(negedge clk);
      waited++;
      rdy = sel ? b_if.ins_ready : a_if.ins_ready;
    end
    if (!rdy) chk("accept_timeout", 32'(waited), 32'd0);
    if (push) begin
      if (sel) qb.push_back('{addr: 5'(d), data: exp});
      else     qa.push_back('{addr: 5'(d), data: exp});
    end
    @(posedge clk);
    #1;
    if (sel) b_if.ins_valid = 1'b0;
    else     a_if.ins_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_if.wb_valid === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; fails++;
        $display("FAIL a_unexpected_wb: got addr %0d data 0x%h, expected no writeback",
                 a_if.wb_addr, a_if.wb_data);
      end else begin
        e = qa.pop_front();
        chk("a_wb_addr", 32'(a_if.wb_addr), 32'(e.addr));
        chk("a_wb_data", a_if.wb_data, e.data);
      end
    end
    if (b_if.wb_valid === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_unexpected_wb: got addr %0d data 0x%h, expected no writeback",
                 b_if.wb_addr, b_if.wb_data);
      end else begin
        e = qb.pop_front();
        chk("b_wb_addr", 32'(b_if.wb_addr), 32'(e.addr));
        chk("b_wb_data", 32'(b_if.wb_data), e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, lo, wsum;
    rst_a = 1'b0; rst_b = 1'b0;
    a_if.ins = '0; a_if.ins_valid = 1'b0;
    b_if.ins = '0; b_if.ins_valid = 1'b0;
    dbg_a = 5'd5; dbg_b = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", 32'(a_if.wb_valid), 32'd0);
    chk("rst_wb_addr", 32'(a_if.wb_addr), 32'd0);
    chk("rst_wb_data", a_if.wb_data, 32'd0);
    chk("rst_dbg_r5", dbgd_a, 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(a_if.ins_ready), 32'd1);

    // Build constants from reset-zero registers, all distance-1 dependent.
    issue(0, OP_NAND, 1, 0, 0, 32'hFFFF_FFFF, 1, w);
    issue(0, OP_SGT,  3, 1, 0, 32'd1, 1, w);
    issue(0, OP_ADD,  4, 3, 3, 32'd2, 1, w);
    issue(0, OP_ADD,  5, 4, 4, 32'd4, 1, w);
    issue(0, OP_ADD,  1, 5, 3, 32'd5, 1, w);
    issue(0, OP_ADD,  2, 1, 3, 32'd6, 1, w);
    issue(0, OP_ADD,  0, 2, 1, 32'd11, 1, w);
    repeat (2) @(negedge clk);
    dbg_a = 5'd0; #1;
    chk("dbg_r0", dbgd_a, 32'd11);

    issue(0, OP_XOR, 3, 2, 1, 32'd3, 1, w);
    issue(0, OP_ADD, 4, 3, 3, 32'd6, 1, w);
    chk("dep_no_stall", 32'(w), 32'd0);

    issue(0, OP_SLL, 4, 3, 5, 32'd96, 1, w);
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_if.ins_ready) break;
      lo++;
    end
    chk("sll5_ready_low", 32'(lo), 32'd5);
    chk("sll5_no_early_wb", 32'(a_if.wb_valid), 32'd0);
    @(negedge clk);
    chk("sll5_wb_at_k6", 32'(a_if.wb_valid), 32'd1);

    issue(0, OP_SRL, 5, 4, 4, 32'd6, 1, w);
    issue(0, OP_SLL, 6, 3, 0, 32'd3, 1, w);
    chk("srl4_stall", 32'(w), 32'd4);
    issue(0, OP_NAND, 7, 9, 9, 32'hFFFF_FFFF, 1, w);
    chk("sll0_no_stall", 32'(w), 32'd0);
    issue(0, OP_SGT,  8, 7, 9, 32'd1, 1, w);
    issue(0, OP_SGT, 10, 7, 8, 32'd1, 1, w);
    issue(0, OP_SGT, 11, 8, 7, 32'd0, 1, w);
    issue(0, OP_NAND,12, 7, 7, 32'd0, 1, w);
    issue(0, OP_AND, 13, 7, 3, 32'd3, 1, w);
    issue(0, OP_OR,  14, 5, 8, 32'd7, 1, w);
    issue(0, OP_SRL, 15, 7, 31, 32'd1, 1, w);
    repeat (36) @(negedge clk);
    dbg_a = 5'd15; #1;
    chk("dbg_r15", dbgd_a, 32'd1);

    // Reset during the third shift cycle of SLL by 8: no retirement.
    issue(0, OP_SLL, 9, 3, 8, 32'd0, 0, w);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("abort_wb_valid", 32'(a_if.wb_valid), 32'd0);
    rst_a = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i); #1;
      chk($sformatf("abort_reg%0d", i), dbgd_a, 32'd0);
    end
    @(negedge clk);
    chk("abort_ready", 32'(a_if.ins_ready), 32'd1);
    chk("abort_no_wb", 32'(a_if.wb_valid), 32'd0);
    issue(0, OP_NAND, 1, 0, 0, 32'hFFFF_FFFF, 1, w);
    issue(0, OP_ADD,  2, 1, 1, 32'hFFFF_FFFE, 1, w);

    // Barrel shifter, 16-bit datapath: every shift retires in one cycle.
    wsum = 0;
    issue(1, OP_NAND, 1, 0, 0, 32'h0000_FFFF, 1, w); wsum += w;
    issue(1, OP_SLL,  2, 1, 0, 32'h0000_FFFF, 1, w); wsum += w;
    issue(1, OP_SLL,  3, 1, 31, 32'h0000_0000, 1, w); wsum += w;
    issue(1, OP_SRL,  4, 1, 15, 32'h0000_0001, 1, w); wsum += w;
    issue(1, OP_SLL,  5, 4, 15, 32'h0000_8000, 1, w); wsum += w;
    issue(1, OP_SRL,  6, 1, 16, 32'h0000_0000, 1, w); wsum += w;
    issue(1, OP_SRL,  7, 5, 3, 32'h0000_1000, 1, w); wsum += w;
    issue(1, OP_ADD,  8, 1, 4, 32'h0000_0000, 1, w); wsum += w;
    chk("barrel_no_stall", 32'(wsum), 32'd0);

    repeat (4) @(negedge clk);
    dbg_b = 5'd5; #1;
    chk("b_dbg_r5", 32'(dbgd_b), 32'h0000_8000);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
